mem_store_buffer: RTL and testbench



---
 rtl/mem_store_buffer.sv | 141 ++++++++++++++
 tb/tb_mem_store_buffer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the MEM stage and a word-addressed data
// memory. Stores are queued in a small circular FIFO and drained to memory
// whenever the single memory port is not claimed by a load that misses.
// Loads hit the buffer through youngest-entry forwarding, or else read memory
// combinationally in the same cycle.
module mem_store_buffer #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  MemReadMEM,
  input  logic                  MemWriteMEM,
  input  logic [ADDR_WIDTH-1:0] ALUSrc1MEM,
  input  logic [DATA_WIDTH-1:0] rtMEM,
  input  logic [DATA_WIDTH-1:0] memDataIn,
  output logic                  memReadEn,
  output logic                  memWriteEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWriteData,
  output logic [DATA_WIDTH-1:0] loadDataOut,
  output logic                  stallMEM,
  output logic                  bufferEmpty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]      head_r;
  logic [PTR_W-1:0]      tail_r;
  logic [CNT_W-1:0]      count_r;

  logic [PTR_W-1:0]      slot_s [DEPTH];
  logic [DEPTH-1:0]      match_s;
  logic                  hit_s;
  logic [DATA_WIDTH-1:0] hit_data_s;
  logic                  load_s;
  logic                  miss_load_s;
  logic                  port_claim_s;
  logic                  drain_s;
  logic                  full_s;
  logic                  stall_s;
  logic                  enq_s;

  // Compare the load/store address against every valid entry, oldest first.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_s[i]  = head_r + PTR_W'(i);
      match_s[i] = (CNT_W'(i) < count_r) && (addr_mem_r[slot_s[i]] == ALUSrc1MEM);
    end
  end

  // Pick the youngest matching entry: later (younger) matches override older ones.
  always_comb begin
    hit_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      hit_data_s = match_s[i] ? data_mem_r[slot_s[i]] : hit_data_s;
    end
    hit_s = |match_s;
  end

  // Port arbitration and queue control. A read request that misses reserves the
  // memory port for the whole cycle, even when it coincides with a store.
  always_comb begin
    load_s       = MemReadMEM && !MemWriteMEM;
    miss_load_s  = load_s && !hit_s;
    port_claim_s = MemReadMEM && !hit_s;
    full_s       = (count_r == FULL_CNT);
    stall_s      = MemWriteMEM && full_s;
    enq_s        = MemWriteMEM && !full_s;
    drain_s      = (count_r != {CNT_W{1'b0}}) && !port_claim_s;
  end

  // Memory-port and pipeline outputs; all forced quiet while reset is held.
  always_comb begin
    memReadEn    = 1'b0;
    memWriteEn   = 1'b0;
    memAddr      = {ADDR_WIDTH{1'b0}};
    memWriteData = {DATA_WIDTH{1'b0}};
    loadDataOut  = {DATA_WIDTH{1'b0}};
    stallMEM     = 1'b0;
    bufferEmpty  = 1'b1;
    if (reset_n) begin
      memReadEn   = miss_load_s;
      memWriteEn  = drain_s;
      stallMEM    = stall_s;
      bufferEmpty = (count_r == {CNT_W{1'b0}});
      if (miss_load_s) begin
        memAddr = ALUSrc1MEM;
      end else if (drain_s) begin
        memAddr = addr_mem_r[head_r];
      end else begin
        memAddr = {ADDR_WIDTH{1'b0}};
      end
      if (drain_s) begin
        memWriteData = data_mem_r[head_r];
      end else begin
        memWriteData = {DATA_WIDTH{1'b0}};
      end
      if (load_s) begin
        loadDataOut = hit_s ? hit_data_s : memDataIn;
      end else begin
        loadDataOut = {DATA_WIDTH{1'b0}};
      end
    end else begin
      memReadEn = 1'b0;
    end
  end

  // FIFO storage, pointers and occupancy; reset discards all pending stores.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_r[i] <= {ADDR_WIDTH{1'b0}};
        data_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (enq_s) begin
        addr_mem_r[tail_r] <= ALUSrc1MEM;
        data_mem_r[tail_r] <= rtMEM;
        tail_r             <= tail_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      if (drain_s) begin
        head_r <= head_r + {{(PTR_W-1){1'b0}}, 1'b1};
      end
      case ({enq_s, drain_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
module tb_mem_store_buffer;

  logic        clock;
  logic        reset_n;
  logic        MemReadMEM;
  logic        MemWriteMEM;
  logic [31:0] ALUSrc1MEM;
  logic [31:0] rtMEM;
  logic [31:0] memDataIn;
  logic        memReadEn;
  logic        memWriteEn;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] loadDataOut;
  logic        stallMEM;
  logic        bufferEmpty;

  mem_store_buffer #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .MemReadMEM   (MemReadMEM),
    .MemWriteMEM  (MemWriteMEM),
    .ALUSrc1MEM   (ALUSrc1MEM),
    .rtMEM        (rtMEM),
    .memDataIn    (memDataIn),
    .memReadEn    (memReadEn),
    .memWriteEn   (memWriteEn),
    .memAddr      (memAddr),
    .memWriteData (memWriteData),
    .loadDataOut  (loadDataOut),
    .stallMEM     (stallMEM),
    .bufferEmpty  (bufferEmpty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory driven by the DUT port (synchronous write, combinational read).
  logic [31:0] phys_mem [16];
  assign memDataIn = phys_mem[memAddr[3:0]];
  always @(posedge clock) begin
    if (memWriteEn) phys_mem[memAddr[3:0]] <= memWriteData;
  end

  // Reference model: an ordered list of pending stores plus the memory image
  // those stores produce once they retire in order.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        q[$];
  logic [31:0] ref_mem [16];

  int checks_cnt = 0;
  int errors_cnt = 0;

  logic [31:0] obs_load, obs_waddr, obs_wdata;
  logic        obs_re, obs_we, obs_stall;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // One pipeline cycle: called just after a rising edge.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic        is_load, hit, rd_miss, drain, stall;
    logic [31:0] hd, e_addr, e_wdata, e_load;
    MemReadMEM  = rd;
    MemWriteMEM = wr;
    ALUSrc1MEM  = a;
    rtMEM       = d;
    is_load = rd && !wr;
    hit = 1'b0;
    hd  = 32'd0;
    foreach (q[i]) begin
      if (q[i].a == a) begin
        hit = 1'b1;
        hd  = q[i].d;
      end
    end
    rd_miss = rd && !hit;
    drain   = (q.size() > 0) && !rd_miss;
    stall   = wr && (q.size() == 4);
    if (is_load && !hit)  e_addr = a;
    else if (drain)       e_addr = q[0].a;
    else                  e_addr = 32'd0;
    e_wdata = drain ? q[0].d : 32'd0;
    if (!is_load)  e_load = 32'd0;
    else if (hit)  e_load = hd;
    else           e_load = ref_mem[a[3:0]];
    @(negedge clock);
    obs_load = loadDataOut; obs_re = memReadEn; obs_we = memWriteEn;
    obs_waddr = memAddr; obs_wdata = memWriteData; obs_stall = stallMEM;
    check_val("memReadEn",   {31'd0, memReadEn},   {31'd0, is_load && !hit});
    check_val("memWriteEn",  {31'd0, memWriteEn},  {31'd0, drain});
    check_val("memAddr",     memAddr,              e_addr);
    check_val("memWriteData", memWriteData,        e_wdata);
    check_val("loadDataOut", loadDataOut,          e_load);
    check_val("stallMEM",    {31'd0, stallMEM},    {31'd0, stall});
    check_val("bufferEmpty", {31'd0, bufferEmpty}, {31'd0, q.size() == 0});
    @(posedge clock);
    if (drain) begin
      ref_mem[q[0].a[3:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (wr && !stall) q.push_back('{a: a, d: d});
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      phys_mem[i] = 32'h100 + 32'(i);
      ref_mem[i]  = 32'h100 + 32'(i);
    end
    phys_mem[5] = 32'd0;    ref_mem[5] = 32'd0;
    phys_mem[4] = 32'd1024; ref_mem[4] = 32'd1024;

    // Reset state, with a load request present to prove outputs are forced.
    reset_n = 1'b0; MemReadMEM = 1'b1; MemWriteMEM = 1'b0;
    ALUSrc1MEM = 32'd3; rtMEM = 32'd0;
    #12;
    check_val("rst_memReadEn",   {31'd0, memReadEn},   32'd0);
    check_val("rst_memWriteEn",  {31'd0, memWriteEn},  32'd0);
    check_val("rst_loadDataOut", loadDataOut,          32'd0);
    check_val("rst_stallMEM",    {31'd0, stallMEM},    32'd0);
    check_val("rst_bufferEmpty", {31'd0, bufferEmpty}, 32'd1);
    check_val("rst_memAddr",     memAddr,              32'd0);
    MemReadMEM = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic drain.
    step(1'b0, 1'b1, 32'd2, 32'd31);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    check_val("drain_we",    {31'd0, obs_we}, 32'd1);
    check_val("drain_addr",  obs_waddr, 32'd2);
    check_val("drain_data",  obs_wdata, 32'd31);
    step(1'b0, 1'b0, 32'd0, 32'd0);

    // Forwarding: get 5/7 and 5/9 both pending, then load 5.
    step(1'b0, 1'b1, 32'd13, 32'd1);
    step(1'b1, 1'b1, 32'd5, 32'd7);
    step(1'b1, 1'b1, 32'd5, 32'd9);
    step(1'b1, 1'b0, 32'd5, 32'd0);
    check_val("fwd_load", obs_load, 32'd9);
    check_val("fwd_re",   {31'd0, obs_re}, 32'd0);
    check_val("fwd_we",   {31'd0, obs_we}, 32'd1);
    check_val("fwd_wdata", obs_wdata, 32'd7);
    step(1'b0, 1'b0, 32'd0, 32'd0);

    // Load miss blocks the drain.
    step(1'b0, 1'b1, 32'd3, 32'd77);
    step(1'b1, 1'b0, 32'd4, 32'd0);
    check_val("miss_load", obs_load, 32'd1024);
    check_val("miss_re",   {31'd0, obs_re}, 32'd1);
    check_val("miss_addr", obs_waddr, 32'd4);
    check_val("miss_we",   {31'd0, obs_we}, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    check_val("miss_late_we",   {31'd0, obs_we}, 32'd1);
    check_val("miss_late_addr", obs_waddr, 32'd3);

    // Fill to full, stall, accept after drain, wrap-around order.
    step(1'b0, 1'b1, 32'd1, 32'd100);
    step(1'b1, 1'b1, 32'd2, 32'd101);
    step(1'b1, 1'b1, 32'd3, 32'd102);
    step(1'b1, 1'b1, 32'd7, 32'd103);
    step(1'b0, 1'b1, 32'd6, 32'd104);
    check_val("full_stall", {31'd0, obs_stall}, 32'd1);
    check_val("full_we",    {31'd0, obs_we}, 32'd1);
    check_val("full_addr",  obs_waddr, 32'd1);
    step(1'b0, 1'b1, 32'd6, 32'd104);
    check_val("full_accept", {31'd0, obs_stall}, 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Illegal read+write at the same time behaves as a store.
    step(1'b1, 1'b1, 32'd6, 32'd10);
    check_val("both_re",   {31'd0, obs_re}, 32'd0);
    check_val("both_load", obs_load, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0);
    check_val("both_drain_addr", obs_waddr, 32'd6);
    check_val("both_drain_data", obs_wdata, 32'd10);

    // Reset while stores are pending and a drain is in progress.
    step(1'b0, 1'b1, 32'd8, 32'd200);
    step(1'b1, 1'b1, 32'd9, 32'd201);
    step(1'b1, 1'b1, 32'd10, 32'd202);
    MemReadMEM = 1'b0; MemWriteMEM = 1'b0;
    #2;
    check_val("pre_rst_we", {31'd0, memWriteEn}, 32'd1);
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_empty", {31'd0, bufferEmpty}, 32'd1);
    check_val("mid_rst_we",    {31'd0, memWriteEn},  32'd0);
    q.delete();
    @(negedge clock); #1 reset_n = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 3)      step(1'b0, 1'b0, 32'($urandom_range(0, 7)), $urandom);
      else if (r < 6) step(1'b0, 1'b1, 32'($urandom_range(0, 7)), $urandom);
      else if (r < 9) step(1'b1, 1'b0, 32'($urandom_range(0, 7)), $urandom);
      else            step(1'b1, 1'b1, 32'($urandom_range(0, 7)), $urandom);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'd0, 32'd0);

    // Final memory image must equal in-order retirement of all accepted stores.
    for (int i = 0; i < 16; i++) check_val($sformatf("mem[%0d]", i), phys_mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
